trigger_coincidence: RTL and testbench

Forms the two trigger primitives consumed by the event builder's trigger decision logic: CosmicCoincidence, a tracker-layer coincidence stretched into a long window, and EnrgCoincidence, an energy-detector trigger delayed so its rising edge lands inside that window. It sits directly upstream of the trigger decision logic. It takes raw per-board trigger primitives (synchronous to Clock) and applies the same masks, so that a combined trigger is a tracker window followed by an energy rising edge.

---
 rtl/pct_trg_pkg.sv | 19 +
 rtl/trg_edge_window.sv | 49 ++++
 rtl/trigger_coincidence.sv | 134 +++++++++++++
 tb/tb_trigger_coincidence.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pct_trg_pkg.sv
// Shared widths and helpers for the tracker/energy trigger coincidence slice.
package pct_trg_pkg;

    localparam int unsigned NTKR_DEF   = 8;
    localparam int unsigned NCAL_DEF   = 2;
    localparam int unsigned TKR_WIN_W  = 4;
    localparam int unsigned TKR_STR_W  = 6;
    localparam int unsigned ENRG_DLY_W = 5;
    localparam int unsigned ENRG_STR_W = 4;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned SR_DEPTH   = 32;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : cnt_t'(v + 1'b1);
    endfunction

endpackage

// File: rtl/trg_edge_window.sv
// One tracker channel: two-stage input register, rising-edge detect and a
// window counter that keeps the channel armed for a programmable number of cycles.
module trg_edge_window
    import pct_trg_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 raw,
    input  logic                 enable,
    input  logic [TKR_WIN_W-1:0] load_val,
    input  logic                 clear,
    output logic                 rise,
    output logic                 armed
);

    logic                 r1_q, r1_d;
    logic                 r2_q, r2_d;
    logic [TKR_WIN_W-1:0] cnt_q, cnt_d;

    always_comb begin
        r1_d = raw;
        r2_d = r1_q;
        rise = r1_q & ~r2_q;
        // a firing coincidence wins over a same-cycle load
        if (clear) begin
            cnt_d = '0;
        end else if (rise && enable) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
        armed = (cnt_q != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_q  <= 1'b0;
            r2_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            r1_q  <= r1_d;
            r2_q  <= r2_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/trigger_coincidence.sv
// Tracker-layer coincidence stretched into a window, plus a delayed and
// stretched energy trigger meant to land inside that window.
module trigger_coincidence
    import pct_trg_pkg::*;
#(
    parameter int unsigned NTKR = NTKR_DEF,
    parameter int unsigned NCAL = NCAL_DEF
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [NTKR-1:0]       TkrTrgIn,
    input  logic [NCAL-1:0]       EnrgTrgIn,
    input  logic [NTKR-1:0]       TkrTrgMsk,
    input  logic [NCAL-1:0]       CalTrgMsk,
    input  logic [TKR_WIN_W-1:0]  TkrWindow,
    input  logic [TKR_STR_W-1:0]  TkrStretch,
    input  logic [ENRG_DLY_W-1:0] EnrgDelay,
    input  logic [ENRG_STR_W-1:0] EnrgStretch,
    output logic                  CosmicCoincidence,
    output logic                  EnrgCoincidence,
    output logic [CNT_W-1:0]      NTkrCoinc,
    output logic [CNT_W-1:0]      NEnrgDrop
);

    logic [NTKR-1:0] tkr_rise;
    logic [NTKR-1:0] tkr_armed;
    logic [NTKR-1:0] tkr_ok;
    logic            tkr_fire;

    logic                  cosmic_q, cosmic_d;
    logic [TKR_STR_W-1:0]  tkr_str_q, tkr_str_d;
    cnt_t                  n_tkr_q, n_tkr_d;

    logic [NCAL-1:0]       e_r1_q, e_r1_d;
    logic [NCAL-1:0]       e_r2_q, e_r2_d;
    logic [SR_DEPTH-1:0]   sr_q, sr_d;
    logic [SR_DEPTH:0]     tap_vec;
    logic                  epls;
    logic                  e_dly;

    logic                  enrg_q, enrg_d;
    logic [ENRG_STR_W-1:0] enrg_str_q, enrg_str_d;
    cnt_t                  n_drop_q, n_drop_d;

    for (genvar i = 0; i < NTKR; i++) begin : g_tkr
        trg_edge_window u_win (
            .clk      (Clock),
            .rst      (Reset),
            .raw      (TkrTrgIn[i]),
            .enable   (TkrTrgMsk[i] & ~cosmic_q),
            .load_val (TkrWindow),
            .clear    (tkr_fire),
            .rise     (tkr_rise[i]),
            .armed    (tkr_armed[i])
        );
    end

    always_comb begin
        tkr_ok   = ~TkrTrgMsk | tkr_armed | tkr_rise;
        tkr_fire = (TkrTrgMsk != '0) && !cosmic_q && (&tkr_ok);

        cosmic_d  = cosmic_q;
        tkr_str_d = tkr_str_q;
        n_tkr_d   = n_tkr_q;
        if (tkr_fire) begin
            cosmic_d  = 1'b1;
            tkr_str_d = TkrStretch;
            n_tkr_d   = sat_inc(n_tkr_q);
        end else if (cosmic_q) begin
            if (tkr_str_q == '0) begin
                cosmic_d = 1'b0;
            end else begin
                tkr_str_d = tkr_str_q - 1'b1;
            end
        end
    end

    always_comb begin
        e_r1_d = EnrgTrgIn;
        e_r2_d = e_r1_q;
        epls   = |(e_r1_q & ~e_r2_q & CalTrgMsk);
        sr_d   = {sr_q[SR_DEPTH-2:0], epls};
        // tap 0 is the undelayed pulse, tap n is the pulse n cycles later
        tap_vec = {sr_q, epls};
        e_dly   = tap_vec[{1'b0, EnrgDelay}];

        enrg_d     = enrg_q;
        enrg_str_d = enrg_str_q;
        n_drop_d   = n_drop_q;
        if (enrg_q) begin
            if (e_dly) begin
                n_drop_d = sat_inc(n_drop_q);
            end
            if (enrg_str_q == '0) begin
                enrg_d = 1'b0;
            end else begin
                enrg_str_d = enrg_str_q - 1'b1;
            end
        end else if (e_dly) begin
            enrg_d     = 1'b1;
            enrg_str_d = EnrgStretch;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cosmic_q   <= 1'b0;
            tkr_str_q  <= '0;
            n_tkr_q    <= '0;
            e_r1_q     <= '0;
            e_r2_q     <= '0;
            sr_q       <= '0;
            enrg_q     <= 1'b0;
            enrg_str_q <= '0;
            n_drop_q   <= '0;
        end else begin
            cosmic_q   <= cosmic_d;
            tkr_str_q  <= tkr_str_d;
            n_tkr_q    <= n_tkr_d;
            e_r1_q     <= e_r1_d;
            e_r2_q     <= e_r2_d;
            sr_q       <= sr_d;
            enrg_q     <= enrg_d;
            enrg_str_q <= enrg_str_d;
            n_drop_q   <= n_drop_d;
        end
    end

    assign CosmicCoincidence = cosmic_q;
    assign EnrgCoincidence   = enrg_q;
    assign NTkrCoinc         = n_tkr_q;
    assign NEnrgDrop         = n_drop_q;

endmodule

// File: tb/tb_trigger_coincidence.sv
// Directed bench for trigger_coincidence with hand-computed expectations.
module tb_trigger_coincidence;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [7:0]  TkrTrgIn;
    logic [1:0]  EnrgTrgIn;
    logic [7:0]  TkrTrgMsk;
    logic [1:0]  CalTrgMsk;
    logic [3:0]  TkrWindow;
    logic [5:0]  TkrStretch;
    logic [4:0]  EnrgDelay;
    logic [3:0]  EnrgStretch;
    logic        CosmicCoincidence;
    logic        EnrgCoincidence;
    logic [15:0] NTkrCoinc;
    logic [15:0] NEnrgDrop;

    int n_checks = 0;
    int n_err    = 0;
    int hc;
    int ec;

    trigger_coincidence #(.NTKR(8), .NCAL(2)) dut (
        .Clock             (Clock),
        .Reset             (Reset),
        .TkrTrgIn          (TkrTrgIn),
        .EnrgTrgIn         (EnrgTrgIn),
        .TkrTrgMsk         (TkrTrgMsk),
        .CalTrgMsk         (CalTrgMsk),
        .TkrWindow         (TkrWindow),
        .TkrStretch        (TkrStretch),
        .EnrgDelay         (EnrgDelay),
        .EnrgStretch       (EnrgStretch),
        .CosmicCoincidence (CosmicCoincidence),
        .EnrgCoincidence   (EnrgCoincidence),
        .NTkrCoinc         (NTkrCoinc),
        .NEnrgDrop         (NEnrgDrop)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset       = 1'b1;
        TkrTrgIn    = '0;
        EnrgTrgIn   = '0;
        TkrTrgMsk   = 8'h0F;
        CalTrgMsk   = 2'b01;
        TkrWindow   = 4'd3;
        TkrStretch  = 6'd19;
        EnrgDelay   = 5'd10;
        EnrgStretch = 4'd2;
        repeat (2) tick();
        Reset = 1'b0;
        check("rst_cosmic", 32'(CosmicCoincidence), 32'd0);
        check("rst_enrg",   32'(EnrgCoincidence),   32'd0);
        check("rst_ntkr",   32'(NTkrCoinc),         32'd0);
        check("rst_ndrop",  32'(NEnrgDrop),         32'd0);

        // layer 3 four edges after layer 0: outside a window of 3
        TkrTrgIn = 8'h01; tick();
        TkrTrgIn = 8'h03; tick();
        TkrTrgIn = 8'h07; tick();
        tick();
        TkrTrgIn = 8'h0F; tick();
        hc = 0;
        repeat (10) begin tick(); if (CosmicCoincidence) hc++; end
        check("late_layer_nofire", 32'(hc), 32'd0);
        check("late_layer_ntkr", 32'(NTkrCoinc), 32'd0);
        TkrTrgIn = '0;
        repeat (6) tick();

        // window 0: adjacent edges never coincide
        TkrWindow = 4'd0;
        TkrTrgIn = 8'h01; tick();
        TkrTrgIn = 8'h0F; tick();
        hc = 0;
        repeat (6) begin tick(); if (CosmicCoincidence) hc++; end
        check("win0_nofire", 32'(hc), 32'd0);
        TkrTrgIn = '0;
        TkrWindow = 4'd3;
        repeat (6) tick();

        // staggered layers 0..3 at d = 0,1,2,3
        TkrTrgIn = 8'h01; tick();
        TkrTrgIn = 8'h03; tick();
        TkrTrgIn = 8'h07; tick();
        TkrTrgIn = 8'h0F; tick();
        check("stagger_before", 32'(CosmicCoincidence), 32'd0);
        tick();
        check("stagger_fire", 32'(CosmicCoincidence), 32'd1);
        hc = 1;
        repeat (25) begin tick(); if (CosmicCoincidence) hc++; end
        check("stagger_len", 32'(hc), 32'd20);
        check("stagger_low", 32'(CosmicCoincidence), 32'd0);
        check("stagger_ntkr", 32'(NTkrCoinc), 32'd1);
        TkrTrgIn = '0;
        repeat (6) tick();

        // fire, then re-pulse all layers during the stretch
        TkrTrgIn = 8'h0F; tick();
        tick();
        check("repulse_fire", 32'(CosmicCoincidence), 32'd1);
        hc = 1;
        for (int i = 0; i < 30; i++) begin
            if (i == 2) TkrTrgIn = '0;
            if (i == 5) TkrTrgIn = 8'h0F;
            tick();
            if (CosmicCoincidence) hc++;
        end
        check("repulse_noext", 32'(hc), 32'd20);
        check("repulse_ntkr", 32'(NTkrCoinc), 32'd2);
        TkrTrgIn = '0;
        repeat (3) tick();
        TkrTrgIn = 8'h0F; tick();
        tick();
        check("refire", 32'(CosmicCoincidence), 32'd1);
        check("refire_ntkr", 32'(NTkrCoinc), 32'd3);
        TkrTrgIn = '0;
        repeat (25) tick();

        // energy delay 10, stretch 2
        EnrgTrgIn = 2'b01; tick();
        EnrgTrgIn = '0;
        ec = 0;
        repeat (10) begin tick(); if (EnrgCoincidence) ec++; end
        check("enrg_early", 32'(ec), 32'd0);
        tick(); check("enrg_c1", 32'(EnrgCoincidence), 32'd1);
        tick(); check("enrg_c2", 32'(EnrgCoincidence), 32'd1);
        tick(); check("enrg_c3", 32'(EnrgCoincidence), 32'd1);
        tick(); check("enrg_end", 32'(EnrgCoincidence), 32'd0);

        EnrgTrgIn = 2'b10; tick();
        EnrgTrgIn = '0;
        ec = 0;
        repeat (20) begin tick(); if (EnrgCoincidence) ec++; end
        check("enrg_masked", 32'(ec), 32'd0);

        // two pulses two cycles apart inside a 6-cycle stretch
        EnrgStretch = 4'd5;
        EnrgTrgIn = 2'b01; tick();
        EnrgTrgIn = '0;    tick();
        EnrgTrgIn = 2'b01; tick();
        EnrgTrgIn = '0;
        ec = 0;
        repeat (25) begin tick(); if (EnrgCoincidence) ec++; end
        check("enrg_pair_len", 32'(ec), 32'd6);
        check("enrg_drop", 32'(NEnrgDrop), 32'd1);

        // zero delay, zero stretch
        EnrgDelay = 5'd0;
        EnrgStretch = 4'd0;
        EnrgTrgIn = 2'b01; tick();
        EnrgTrgIn = '0;
        check("d0_before", 32'(EnrgCoincidence), 32'd0);
        tick(); check("d0_high", 32'(EnrgCoincidence), 32'd1);
        tick(); check("d0_low", 32'(EnrgCoincidence), 32'd0);

        // reset mid-stretch with an energy pulse in the delay line
        EnrgDelay = 5'd10;
        EnrgStretch = 4'd2;
        TkrTrgIn = 8'h0F;
        EnrgTrgIn = 2'b01; tick();
        TkrTrgIn = '0;
        EnrgTrgIn = '0; tick();
        check("pre_rst_fire", 32'(CosmicCoincidence), 32'd1);
        repeat (2) tick();
        Reset = 1'b1; tick();
        Reset = 1'b0;
        check("mid_rst_cosmic", 32'(CosmicCoincidence), 32'd0);
        check("mid_rst_enrg",   32'(EnrgCoincidence),   32'd0);
        check("mid_rst_ntkr",   32'(NTkrCoinc),         32'd0);
        check("mid_rst_ndrop",  32'(NEnrgDrop),         32'd0);
        hc = 0; ec = 0;
        repeat (20) begin
            tick();
            if (CosmicCoincidence) hc++;
            if (EnrgCoincidence) ec++;
        end
        check("post_rst_cosmic", 32'(hc), 32'd0);
        check("post_rst_enrg", 32'(ec), 32'd0);

        // empty mask never fires
        TkrTrgMsk = '0;
        TkrTrgIn = 8'hFF; tick();
        hc = 0;
        repeat (6) begin tick(); if (CosmicCoincidence) hc++; end
        check("mask0_nofire", 32'(hc), 32'd0);
        check("mask0_ntkr", 32'(NTkrCoinc), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
